md_ctrl: RTL
============

// Module: md_ctrl
// PURPOSE
//   Sequences the shared multiply/divide resource for the 5-stage MIPS core. It accepts
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, runs a fixed-latency busy window and
//   commits the result to HI/LO.
//   It also raises md_stall so the hazard logic freezes IF/ID whenever the D-stage instruction
//   uses HI/LO or the md unit while an operation is pending.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..15)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..15)
// PORTS
//   clk       in   1   core clock; all state changes on rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   e_start   in   1   E-stage instruction is a valid md op this cycle (already qualified by flush)
//   e_op      in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   e_a       in   32  forwarded rs value (MFERS)
//   e_b       in   32  forwarded rt value (MFERT)
//   d_md_use  in   1   D-stage instruction is MULT*/DIV*/MFHI/MFLO/MTHI/MTLO
//   busy      out  1   operation in flight
//   md_stall  out  1   to hazard unit: stall PC and IF/ID, insert bubble into ID/EX
//   hi        out  32  architectural HI register
//   lo        out  32  architectural LO register
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, cnt=0, hi=0, lo=0, busy=0, md_stall=0.
//     Reset mid-operation aborts it; the pending result is discarded.
//   FSM states are IDLE and RUN. busy = (state==RUN).
//   IDLE, rising edge with e_start=1:
//     MULT/MULTU/DIV/DIVU: latch result into res_hi/res_lo, cnt<=MULT_CYCLES or DIV_CYCLES,
//       state<=RUN.
//     MTHI: hi<=e_a, state stays IDLE. MTLO: lo<=e_a, state stays IDLE. No busy window.
//     op 11x: no effect.
//   RUN, rising edge: cnt<=cnt-1. When cnt==1, hi<=res_hi, lo<=res_lo, state<=IDLE.
//   Latency: busy is high for exactly N cycles after the start edge. New HI/LO are visible in
//     the first cycle busy is low, so MFHI/MFLO may issue from E in that cycle.
//   e_start while RUN: ignored. The hazard unit guarantees this does not occur; the bench
//     flags it as an error.
//   md_stall = d_md_use & (busy | (e_start & ~e_op[2])). This covers the start cycle, before
//     busy rises. MTHI/MTLO in E do not stall D; bypassing is not required, because MFHI/MFLO
//     in D read hi/lo only after the MT* edge.
//   Arithmetic:
//     MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
//     DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
//       DIVU: unsigned.
//     DIV 0x80000000 / -1: lo=0x80000000, hi=0.
//     Divide by zero (any DIV*): lo=0xFFFFFFFF, hi=e_a. The full DIV_CYCLES window still runs.
//   Flush: e_start arrives pre-qualified. An op already in RUN is never cancelled by a
//     pipeline flush; it always completes, matching MIPS HI/LO semantics.
// STRUCTURE
//   Shared header md_defs.vh: md op codes (MD_MULT..MD_MTLO), state codes, default latencies.
//   Sub-module md_arith: combinational {res_hi,res_lo} from (op,a,b), including the signed,
//     unsigned and zero-divisor rules.
//   md_ctrl itself holds the FSM, 4-bit cnt, result latch and HI/LO registers.
//   Decode of d_md_use is done in the ID/WB control decoder, not here.
// TESTING
//   1. MULT a=7, b=0xFFFFFFFD -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   2. DIVU a=100, b=7 -> busy high 10 cycles; then lo=0x0000000E, hi=0x00000002.
//      DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   3. DIV a=0x12345678, b=0 -> busy 10 cycles; lo=0xFFFFFFFF, hi=0x12345678.
//      DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. MULT issued with d_md_use=1 (MFLO in D) -> md_stall high on the start cycle and all
//      5 busy cycles, low in the cycle hi/lo update; d_md_use=0 -> md_stall stays 0.
//   5. MTHI a=0xCAFEBABE, then MTLO a=0x1 on the next edge -> hi and lo update after one
//      edge each; busy never rises.
//   6. Start DIVU, drop rst_n at busy cycle 4 -> hi=lo=0 and busy=0 immediately (async).
//      After release, an idle cycle leaves hi/lo=0.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e    : E-stage md operation codes (op 11x is a no-op)
//   md_state_e : sequencer FSM states
//   Default busy-window latencies for MULT* and DIV*.
package md_ctrl_pkg;

    typedef enum logic [2:0] {
        MdMult  = 3'b000,
        MdMultu = 3'b001,
        MdDiv   = 3'b010,
        MdDivu  = 3'b011,
        MdMthi  = 3'b100,
        MdMtlo  = 3'b101
    } md_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op     in  3   md op code (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b   in  32  operands (a = rs, b = rt)
//   res_hi out 32  product high word / remainder
//   res_lo out 32  product low word / quotient
// Divide by zero yields lo=all-ones, hi=a. Signed division is done on magnitudes so
// 0x80000000 / -1 naturally wraps to lo=0x80000000, hi=0.
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        b_zero;

    // Sign-extended operands: the low 64 bits of the product equal the signed product.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign abs_a  = a[31] ? (~a + 32'd1) : a;
    assign abs_b  = b[31] ? (~b + 32'd1) : b;
    assign b_zero = (b == 32'd0);

    // Dividers are only evaluated with a non-zero divisor so simulation never sees X.
    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        q_u   = 32'd0;
        r_u   = 32'd0;
        if (!b_zero) begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
            q_u   = a / b;
            r_u   = a % b;
        end
    end

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign q_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s = a[31] ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MdMult:  {res_hi, res_lo} = prod_s;
            MdMultu: {res_hi, res_lo} = prod_u;
            MdDiv: begin
                res_hi = b_zero ? a : r_s;
                res_lo = b_zero ? 32'hFFFF_FFFF : q_s;
            end
            MdDivu: begin
                res_hi = b_zero ? a : r_u;
                res_lo = b_zero ? 32'hFFFF_FFFF : q_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the 5-stage core: accepts md ops from E, runs a fixed
// busy window, then commits the latched result to HI/LO. MTHI/MTLO write immediately.
// Ports:
//   clk, rst_n  in   clock, async active-low reset
//   e_start     in   1   valid md op in E (already flush-qualified)
//   e_op        in   3   md op code
//   e_a, e_b    in   32  forwarded rs / rt
//   d_md_use    in   1   D-stage instruction touches HI/LO or the md unit
//   busy        out  1   operation in flight
//   md_stall    out  1   freeze IF/ID, bubble ID/EX
//   hi, lo      out  32  architectural HI/LO
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] CntMult = 4'(MULT_CYCLES);
    localparam logic [3:0] CntDiv  = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] arith_hi, arith_lo;

    md_arith u_arith (
        .op     (e_op),
        .a      (e_a),
        .b      (e_b),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (e_start) begin
                    case (e_op)
                        MdMult, MdMultu: begin
                            res_hi_d = arith_hi;
                            res_lo_d = arith_lo;
                            cnt_d    = CntMult;
                            state_d  = StRun;
                        end
                        MdDiv, MdDivu: begin
                            res_hi_d = arith_hi;
                            res_lo_d = arith_lo;
                            cnt_d    = CntDiv;
                            state_d  = StRun;
                        end
                        MdMthi:  hi_d = e_a;
                        MdMtlo:  lo_d = e_a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // e_start is ignored here; a running op always completes.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == StRun);
    // Start-cycle term covers the edge before busy rises; MT* never stalls D.
    assign md_stall = d_md_use & (busy | (e_start & ~e_op[2]));
    assign hi = hi_q;
    assign lo = lo_q;

endmodule
